// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO alternate-function blocks.
// Holds the BAM sequencer register map, the bit positions and the FSM encoding.
package gpio_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_PRESC  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_ALT_EN     = 1;
    localparam int STAT_BUSY       = 0;
    localparam int STAT_FRAME_DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bam_ctrl_if.sv
// Register bus between the MIPS data path and the BAM sequencer.
interface bam_ctrl_if;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic [31:0] o_rdata;

    modport master (output i_addr, output i_wdata, output i_we, input o_rdata);
    modport slave  (input i_addr, input i_wdata, input i_we, output o_rdata);
endinterface

// File: rtl/bam_timebase.sv
// BAM slot timebase: prescaler count, tick within the current slot, and slot index.
// frame_end flags the clock whose edge closes slot WIDTH-1.
module bam_timebase #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 16,
    localparam int SLOT_W = $clog2(WIDTH),
    localparam int TW     = WIDTH - 1
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               clr,
    input  logic               adv,
    input  logic [PRESC_W-1:0] presc,
    output logic [SLOT_W-1:0]  slot,
    output logic               frame_end
);

    logic [PRESC_W-1:0] pcnt;
    logic [TW-1:0]      tick;
    logic [TW-1:0]      tick_max;
    logic               pcnt_last;
    logic               tick_last;
    logic               slot_last;

    // For the last slot the shift overflows to 0 and the subtraction wraps
    // to all ones, which is exactly 2^(WIDTH-1)-1.
    assign tick_max  = (TW'(1) << slot) - TW'(1);
    assign pcnt_last = (pcnt == presc);
    assign tick_last = (tick == tick_max);
    assign slot_last = (slot == SLOT_W'(WIDTH - 1));
    assign frame_end = adv & pcnt_last & tick_last & slot_last;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pcnt <= '0;
            tick <= '0;
            slot <= '0;
        end else if (clr) begin
            pcnt <= '0;
            tick <= '0;
            slot <= '0;
        end else if (adv) begin
            if (!pcnt_last) begin
                pcnt <= pcnt + PRESC_W'(1);
            end else begin
                pcnt <= '0;
                if (!tick_last) begin
                    tick <= tick + TW'(1);
                end else begin
                    tick <= '0;
                    slot <= slot_last ? '0 : slot + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bam_ctrl.sv
// Bit-angle-modulation sequencer driving the GPIO alternate-output path.
// Duty and prescaler are shadowed and only change at frame boundaries.
module bam_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 16
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    bam_ctrl_if.slave   bus,
    output logic        o_alt,
    output logic        o_alt_in,
    output logic        o_frame
);

    localparam int SLOT_W = $clog2(WIDTH);

    logic [1:0]         ctrl;
    logic [WIDTH-1:0]   duty;
    logic [PRESC_W-1:0] presc;
    logic               frame_done;
    logic [WIDTH-1:0]   duty_sh;
    logic [PRESC_W-1:0] presc_sh;
    state_t             state;
    logic [SLOT_W-1:0]  slot;
    logic               frame_end;
    logic               enable;
    logic               unused_wdata;

    assign enable       = ctrl[CTRL_ENABLE];
    assign unused_wdata = ^bus.i_wdata;

    bam_timebase #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) u_timebase (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .clr       ((state == IDLE) && enable),
        .adv       ((state == RUN) && enable),
        .presc     (presc_sh),
        .slot      (slot),
        .frame_end (frame_end)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ctrl       <= '0;
            duty       <= '0;
            presc      <= '0;
            frame_done <= 1'b0;
        end else begin
            if (bus.i_we && bus.i_addr == ADDR_CTRL)  ctrl  <= bus.i_wdata[1:0];
            if (bus.i_we && bus.i_addr == ADDR_DUTY)  duty  <= bus.i_wdata[WIDTH-1:0];
            if (bus.i_we && bus.i_addr == ADDR_PRESC) presc <= bus.i_wdata[PRESC_W-1:0];
            // A frame completing on the same edge as a W1C keeps the flag set.
            if (frame_end)
                frame_done <= 1'b1;
            else if (bus.i_we && bus.i_addr == ADDR_STATUS && bus.i_wdata[STAT_FRAME_DONE])
                frame_done <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state    <= IDLE;
            duty_sh  <= '0;
            presc_sh <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        duty_sh  <= duty;
                        presc_sh <= presc;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (frame_end) begin
                        duty_sh  <= duty;
                        presc_sh <= presc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_alt    = ctrl[CTRL_ALT_EN];
    assign o_alt_in = (state == RUN) && duty_sh[slot];
    assign o_frame  = frame_end;

    always_comb begin
        bus.o_rdata = '0;
        case (bus.i_addr)
            ADDR_CTRL:   bus.o_rdata[1:0]         = ctrl;
            ADDR_DUTY:   bus.o_rdata[WIDTH-1:0]   = duty;
            ADDR_PRESC:  bus.o_rdata[PRESC_W-1:0] = presc;
            ADDR_STATUS: begin
                bus.o_rdata[STAT_BUSY]       = (state == RUN);
                bus.o_rdata[STAT_FRAME_DONE] = frame_done;
            end
            default: bus.o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_bam_ctrl.sv
// Scoreboard bench for bam_ctrl (WIDTH=4): a frame-position model predicts every cycle.
module tb_bam_ctrl;

    localparam int W  = 4;
    localparam int PW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic alt, alt_in, frame;

    always #5 clk = ~clk;

    bam_ctrl_if bus ();

    bam_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus),
        .o_alt    (alt),
        .o_alt_in (alt_in),
        .o_frame  (frame)
    );

    typedef struct {
        logic        alt;
        logic        alt_in;
        logic        frame;
        logic [31:0] rdata;
        logic [1:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: position inside the current frame, not counters.
    logic [1:0]  m_ctrl;
    logic [W-1:0] m_duty, m_dsh;
    logic [PW-1:0] m_presc, m_psh;
    logic        m_done, m_run;
    int          m_pos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_duty = '0; m_dsh = '0; m_presc = '0; m_psh = '0;
        m_done = 1'b0; m_run = 1'b0; m_pos = 0;
    endtask

    function automatic int m_flen();
        return ((1 << W) - 1) * (int'(m_psh) + 1);
    endfunction

    function automatic logic m_altin();
        int u, k;
        if (!m_run) return 1'b0;
        u = m_pos / (int'(m_psh) + 1);
        k = 0;
        while (k < W - 1 && u >= (1 << (k + 1)) - 1) k++;
        return m_dsh[k];
    endfunction

    function automatic logic m_frame();
        return m_run && m_ctrl[0] && (m_pos == m_flen() - 1);
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {30'b0, m_ctrl};
            2'd1:    return {28'b0, m_duty};
            2'd2:    return {24'b0, m_presc};
            default: return {30'b0, m_done, m_run};
        endcase
    endfunction

    task automatic model_edge(input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        logic fe;
        fe = m_frame();
        if (!m_run) begin
            if (m_ctrl[0]) begin
                m_run = 1'b1; m_dsh = m_duty; m_psh = m_presc; m_pos = 0;
            end
        end else if (!m_ctrl[0]) begin
            m_run = 1'b0;
        end else if (fe) begin
            m_dsh = m_duty; m_psh = m_presc; m_pos = 0;
        end else begin
            m_pos++;
        end
        if (fe) m_done = 1'b1;
        else if (we && addr == 2'd3 && wdata[1]) m_done = 1'b0;
        if (we) begin
            case (addr)
                2'd0: m_ctrl  = wdata[1:0];
                2'd1: m_duty  = wdata[W-1:0];
                2'd2: m_presc = wdata[PW-1:0];
                default: ;
            endcase
        end
    endtask

    // Called at posedge+1: drive, predict this cycle, cross one edge.
    task automatic cycle(input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        exp_t e;
        bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
        e.alt = m_ctrl[1]; e.alt_in = m_altin(); e.frame = m_frame();
        e.rdata = m_rd(addr); e.addr = addr;
        sb.push_back(e);
        @(posedge clk); #1;
        model_edge(we, addr, wdata);
        bus.i_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        cycle(1'b1, addr, data);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 2'($urandom_range(0, 3)), 32'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("o_alt", {31'b0, alt}, {31'b0, e.alt});
                check("o_alt_in", {31'b0, alt_in}, {31'b0, e.alt_in});
                check("o_frame", {31'b0, frame}, {31'b0, e.frame});
                check($sformatf("o_rdata[%0d]", e.addr), bus.o_rdata, e.rdata);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [14:0] pat, frm;
        logic        found;
        int          r;
        model_reset();
        bus.i_we = 1'b0; bus.i_addr = 2'd0; bus.i_wdata = '0;

        #2;
        check("rst_alt", {31'b0, alt}, 32'd0);
        check("rst_alt_in", {31'b0, alt_in}, 32'd0);
        check("rst_frame", {31'b0, frame}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.i_addr = 2'(a); #1;
            check($sformatf("rst_rdata[%0d]", a), bus.o_rdata, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic frame: duty 0101, no prescaling.
        wr(2'd2, 32'd0); wr(2'd1, 32'h5); wr(2'd0, 32'h1);
        idle(1);
        for (int i = 0; i < 15; i++) begin
            pat[i] = alt_in; frm[i] = frame;
            idle(1);
        end
        check("basic_pattern", {17'b0, pat}, 32'h0079);
        check("basic_frame_pulse", {17'b0, frm}, 32'h4000);
        bus.i_addr = 2'd3; #1;
        check("basic_status", bus.o_rdata, 32'h3);

        // Prescaler 2, duty 1000.
        wr(2'd0, 32'h0); idle(2);
        wr(2'd2, 32'd2); wr(2'd1, 32'h8); wr(2'd0, 32'h1);
        idle(100);

        // Duty changed mid-frame only lands at the next frame.
        wr(2'd0, 32'h0); idle(2);
        wr(2'd2, 32'd0); wr(2'd1, 32'hF); wr(2'd0, 32'h1);
        idle(5); wr(2'd1, 32'h0); idle(30);

        // Disable mid-frame, then restart with a new duty.
        wr(2'd1, 32'h6); idle(7);
        wr(2'd0, 32'h0); idle(3);
        wr(2'd1, 32'h9); wr(2'd0, 32'h1); idle(20);

        // W1C on the frame-end edge: set must win.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_frame()) begin
                wr(2'd3, 32'h2);
                found = 1'b1;
            end else begin
                idle(1);
            end
        end
        check("w1c_race_found", {31'b0, found}, 32'd1);
        bus.i_addr = 2'd3; #1;
        check("w1c_race_done", {31'b0, bus.o_rdata[1]}, 32'd1);
        wr(2'd3, 32'hFFFF_FFFF); idle(2);

        // ALT enable without running.
        wr(2'd0, 32'h2); idle(2);
        check("alt_idle_alt", {31'b0, alt}, 32'd1);
        check("alt_idle_alt_in", {31'b0, alt_in}, 32'd0);

        // Randomized traffic.
        repeat (3000) begin
            r = $urandom_range(0, 99);
            if (r < 3)       wr(2'd0, $urandom);
            else if (r < 6)  wr(2'd0, $urandom | 32'h1);
            else if (r < 10) wr(2'd1, $urandom);
            else if (r < 13) wr(2'd2, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3)));
            else if (r < 16) wr(2'd3, $urandom);
            else             idle(1);
        end

        // Asynchronous reset mid-run with a write in flight.
        wr(2'd2, 32'd1); wr(2'd1, 32'hB); wr(2'd0, 32'h3); idle(10);
        bus.i_we = 1'b1; bus.i_addr = 2'd1; bus.i_wdata = 32'hF;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_alt", {31'b0, alt}, 32'd0);
        check("mid_rst_alt_in", {31'b0, alt_in}, 32'd0);
        check("mid_rst_frame", {31'b0, frame}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.i_addr = 2'(a); #1;
            check($sformatf("mid_rst_rdata[%0d]", a), bus.o_rdata, 32'd0);
        end
        bus.i_we = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        idle(5);
        wr(2'd1, 32'hC); wr(2'd0, 32'h1); idle(40);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
